// File: rtl/nec_command_decoder.sv
// nec_command_decoder: validates NEC frames, tags key repeats, and queues them in a 4-deep show-ahead FIFO.
module nec_command_decoder #(
    parameter int          CLOCK_SPEED      = 50_000,
    parameter int          HOLD_TIMEOUT_MS  = 150,
    parameter bit          EXTENDED_ADDRESS = 1'b0,
    parameter bit          ADDRESS_FILTER   = 1'b0,
    parameter logic [15:0] ADDRESS          = 16'h0000,
    parameter bit          DROP_REPEATS     = 1'b0
) (
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        dataReceivedIN,
    input  logic [31:0] dataIN,
    input  logic        readyIN,
    output logic        commandValidOUT,
    output logic [7:0]  commandOUT,
    output logic [15:0] addressOUT,
    output logic        repeatOUT,
    output logic        keyHeldOUT,
    output logic        droppedOUT,
    output logic [7:0]  errorCountOUT
);
    typedef enum logic {IDLE, HELD} state_t;

    function automatic logic [7:0] rev(input logic [7:0] x);
        for (int i = 0; i < 8; i++) rev[i] = x[7-i];
    endfunction

    state_t      state_q, state_d;
    logic        v0_q, v0_d, v1_q, v1_d, ok1_q, ok1_d, match1_q, match1_d, drop_q, drop_d;
    logic [31:0] raw_q, raw_d, pre_q, pre_d, ms_q, ms_d;
    logic [7:0]  cmd1_q, cmd1_d, last_cmd_q, last_cmd_d, err_q, err_d;
    logic [15:0] addr1_q, addr1_d, last_addr_q, last_addr_d;
    logic [24:0] mem_q [4];
    logic [24:0] mem_d [4];
    logic [1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  a, na, c, nc;
    logic [15:0] addr_dec;
    logic        held, accept, rep, push_req, pop, full, push, tick, timeout;
    logic [24:0] head;

    always_comb begin
        a        = rev(raw_q[31:24]);
        na       = rev(raw_q[23:16]);
        c        = rev(raw_q[15:8]);
        nc       = rev(raw_q[7:0]);
        addr_dec = EXTENDED_ADDRESS ? {na, a} : {8'h00, a};
        v0_d     = dataReceivedIN;
        raw_d    = dataReceivedIN ? dataIN : raw_q;
        v1_d     = v0_q;
        ok1_d    = ((c ^ nc) == 8'hFF) && (EXTENDED_ADDRESS || ((a ^ na) == 8'hFF));
        match1_d = !ADDRESS_FILTER || (addr_dec == ADDRESS);
        cmd1_d   = c;
        addr1_d  = addr_dec;
        held     = state_q == HELD;
        accept   = v1_q && ok1_q && match1_q;
        rep      = held && (cmd1_q == last_cmd_q) && (addr1_q == last_addr_q);
        push_req = accept && !(rep && DROP_REPEATS);
        pop      = (cnt_q != 3'd0) && readyIN;
        full     = cnt_q == 3'd4;
        push     = push_req && (!full || pop);
        tick     = pre_q == 32'(CLOCK_SPEED - 1);
        timeout  = held && tick && (ms_q == 32'(HOLD_TIMEOUT_MS - 1));
        // An accepted frame beats a coincident timeout and restarts the timer.
        state_d     = accept ? HELD : (timeout ? IDLE : state_q);
        pre_d       = (accept || !held || tick) ? 32'd0 : pre_q + 32'd1;
        ms_d        = (accept || !held || timeout) ? 32'd0 : (tick ? ms_q + 32'd1 : ms_q);
        last_cmd_d  = accept ? cmd1_q : last_cmd_q;
        last_addr_d = accept ? addr1_q : last_addr_q;
        err_d       = (v1_q && !ok1_q && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        drop_d      = push_req && full && !pop;
        rp_d        = pop ? rp_q + 2'd1 : rp_q;
        wp_d        = push ? wp_q + 2'd1 : wp_q;
        cnt_d       = cnt_q + 3'(push) - 3'(pop);
        mem_d       = mem_q;
        if (push) mem_d[wp_q] = {rep, addr1_q, cmd1_q};
        head = mem_q[rp_q];
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q     <= IDLE;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            ok1_q       <= 1'b0;
            match1_q    <= 1'b0;
            drop_q      <= 1'b0;
            raw_q       <= '0;
            pre_q       <= '0;
            ms_q        <= '0;
            cmd1_q      <= '0;
            last_cmd_q  <= '0;
            err_q       <= '0;
            addr1_q     <= '0;
            last_addr_q <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            ok1_q       <= ok1_d;
            match1_q    <= match1_d;
            drop_q      <= drop_d;
            raw_q       <= raw_d;
            pre_q       <= pre_d;
            ms_q        <= ms_d;
            cmd1_q      <= cmd1_d;
            last_cmd_q  <= last_cmd_d;
            err_q       <= err_d;
            addr1_q     <= addr1_d;
            last_addr_q <= last_addr_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign commandValidOUT = cnt_q != 3'd0;
    assign commandOUT      = commandValidOUT ? head[7:0] : 8'h00;
    assign addressOUT      = commandValidOUT ? head[23:8] : 16'h0000;
    assign repeatOUT       = commandValidOUT && head[24];
    assign keyHeldOUT      = held;
    assign droppedOUT      = drop_q;
    assign errorCountOUT   = err_q;
endmodule
